// File: rtl/fetch_unit_if.sv
// Instruction-memory request/acknowledge bus between the fetch unit and imem.
interface fetch_unit_if;
    logic        imem_req;
    logic [63:0] imem_addr;
    logic        imem_ack;
    logic [31:0] imem_rdata;

    modport master (output imem_req, output imem_addr, input imem_ack, input imem_rdata);
    modport slave  (input imem_req, input imem_addr, output imem_ack, output imem_rdata);
endinterface

// File: rtl/fetch_unit.sv
// LEGv8 program-counter register and fetch sequencer: boots, fetches, holds for
// decode, retires, and traps misaligned targets and memory timeouts.
//
// state | meaning
// BOOT  | first edge after reset; load startpc
// FETCH | imem_req high, waiting for imem_ack (bounded by ACK_TIMEOUT)
// HOLD  | instruction valid for decode, waiting for advance
// FAULT | sticky trap; only reset leaves it
module fetch_unit #(
    parameter int ACK_TIMEOUT = 16,
    parameter int CNT_W       = 32
) (
    input  logic              CLK,
    input  logic              resetl,
    input  logic [63:0]       startpc,
    input  logic [63:0]       NextPC,
    input  logic              advance,
    fetch_unit_if.master      imem,
    output logic [63:0]       CurrentPC,
    output logic [31:0]       Instruction,
    output logic              inst_valid,
    output logic [1:0]        fault,
    output logic [CNT_W-1:0]  retired
);

    localparam int TW = (ACK_TIMEOUT > 1) ? $clog2(ACK_TIMEOUT) : 1;
    localparam logic [TW-1:0] TMO_LAST = TW'(ACK_TIMEOUT - 1);

    typedef enum logic [1:0] {
        BOOT  = 2'd0,
        FETCH = 2'd1,
        HOLD  = 2'd2,
        FAULT = 2'd3
    } state_t;

    state_t          state;
    logic [TW-1:0]   tmo_cnt;

    // Request derives straight from the state register so reset drops it asynchronously.
    assign imem.imem_req  = (state == FETCH);
    assign imem.imem_addr = CurrentPC;

    always_ff @(posedge CLK or negedge resetl) begin
        if (!resetl) begin
            state       <= BOOT;
            CurrentPC   <= '0;
            Instruction <= '0;
            inst_valid  <= 1'b0;
            fault       <= 2'b00;
            retired     <= '0;
            tmo_cnt     <= '0;
        end else begin
            case (state)
                BOOT: begin
                    CurrentPC <= startpc;
                    state     <= FETCH;
                end
                FETCH: begin
                    // An ack on the final allowed cycle takes priority over the timeout.
                    if (imem.imem_ack) begin
                        Instruction <= imem.imem_rdata;
                        inst_valid  <= 1'b1;
                        tmo_cnt     <= '0;
                        state       <= HOLD;
                    end else if (tmo_cnt == TMO_LAST) begin
                        fault <= 2'b10;
                        state <= FAULT;
                    end else begin
                        tmo_cnt <= tmo_cnt + 1'b1;
                    end
                end
                HOLD: begin
                    if (advance) begin
                        inst_valid <= 1'b0;
                        if (NextPC[1:0] == 2'b00) begin
                            CurrentPC <= NextPC;
                            retired   <= retired + 1'b1;
                            state     <= FETCH;
                        end else begin
                            fault <= 2'b01;
                            state <= FAULT;
                        end
                    end
                end
                FAULT: begin
                    inst_valid <= 1'b0;
                end
                default: begin
                    state <= FAULT;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_fetch_unit.sv
// Self-checking bench for fetch_unit: directed scenarios plus randomized
// instruction streams checked against a transaction-level PC/retire model.
module tb_fetch_unit;

    localparam int AT = 4;
    localparam int CW = 4;

    logic        CLK = 1'b0;
    logic        resetl = 1'b0;
    logic [63:0] startpc = '0;
    logic [63:0] NextPC = '0;
    logic        advance = 1'b0;
    logic [63:0] CurrentPC;
    logic [31:0] Instruction;
    logic        inst_valid;
    logic [1:0]  fault;
    logic [CW-1:0] retired;

    fetch_unit_if imem ();

    fetch_unit #(.ACK_TIMEOUT(AT), .CNT_W(CW)) dut (
        .CLK        (CLK),
        .resetl     (resetl),
        .startpc    (startpc),
        .NextPC     (NextPC),
        .advance    (advance),
        .imem       (imem.master),
        .CurrentPC  (CurrentPC),
        .Instruction(Instruction),
        .inst_valid (inst_valid),
        .fault      (fault),
        .retired    (retired)
    );

    always #5 CLK = ~CLK;

    int n_vec = 0;
    int n_err = 0;

    // Reference model: architectural view only.
    logic [63:0] m_pc;
    logic [31:0] m_instr;
    int          m_ret;
    logic [1:0]  m_fault;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic [63:0] exp_ret();
        return 64'(m_ret % (1 << CW));
    endfunction

    function automatic logic [63:0] rand_pc();
        logic [63:0] p;
        p = {$urandom(), $urandom()};
        p[1:0] = 2'b00;
        return p;
    endfunction

    task automatic check_reset_vals(input string tag);
        chk({tag, "_req"}, 64'(imem.imem_req), 64'd0);
        chk({tag, "_pc"}, CurrentPC, 64'd0);
        chk({tag, "_instr"}, 64'(Instruction), 64'd0);
        chk({tag, "_valid"}, 64'(inst_valid), 64'd0);
        chk({tag, "_fault"}, 64'(fault), 64'd0);
        chk({tag, "_retired"}, 64'(retired), 64'd0);
    endtask

    task automatic do_reset(input logic [63:0] spc);
        resetl = 1'b0;
        advance = 1'b0;
        imem.imem_ack = 1'b0;
        startpc = spc;
        repeat (3) @(posedge CLK);
        #1;
        check_reset_vals("rst");
        resetl = 1'b1;
        m_pc = spc; m_instr = '0; m_ret = 0; m_fault = 2'b00;
        @(posedge CLK);
        #1;
        chk("boot_req", 64'(imem.imem_req), 64'd1);
        chk("boot_addr", imem.imem_addr, spc);
        chk("boot_pc", CurrentPC, spc);
    endtask

    // Fetch with a given number of no-ack cycles before ack; timeout if too many.
    task automatic fetch(input int waits, input logic [31:0] data);
        for (int i = 1; i <= waits; i++) begin
            imem.imem_ack = 1'b0;
            advance = 1'($urandom);
            NextPC = {$urandom(), $urandom()};
            @(posedge CLK);
            #1;
            if (i == AT) begin
                m_fault = 2'b10;
                advance = 1'b0;
                chk("tmo_fault", 64'(fault), 64'(m_fault));
                chk("tmo_req", 64'(imem.imem_req), 64'd0);
                chk("tmo_valid", 64'(inst_valid), 64'd0);
                return;
            end
            chk("wait_req", 64'(imem.imem_req), 64'd1);
            chk("wait_addr", imem.imem_addr, m_pc);
        end
        imem.imem_ack = 1'b1;
        imem.imem_rdata = data;
        advance = 1'($urandom);
        @(posedge CLK);
        #1;
        imem.imem_ack = 1'b0;
        advance = 1'b0;
        m_instr = data;
        chk("f_valid", 64'(inst_valid), 64'd1);
        chk("f_instr", 64'(Instruction), 64'(data));
        chk("f_pc", CurrentPC, m_pc);
        chk("f_req", 64'(imem.imem_req), 64'd0);
        chk("f_fault", 64'(fault), 64'd0);
    endtask

    task automatic hold_cycles(input int n);
        for (int i = 0; i < n; i++) begin
            advance = 1'b0;
            imem.imem_ack = 1'($urandom);
            imem.imem_rdata = $urandom();
            NextPC = {$urandom(), $urandom()};
            @(posedge CLK);
            #1;
            chk("h_valid", 64'(inst_valid), 64'd1);
            chk("h_instr", 64'(Instruction), 64'(m_instr));
            chk("h_pc", CurrentPC, m_pc);
        end
        imem.imem_ack = 1'b0;
    endtask

    task automatic do_advance(input logic [63:0] np);
        NextPC = np;
        advance = 1'b1;
        imem.imem_ack = 1'($urandom);
        @(posedge CLK);
        #1;
        advance = 1'b0;
        imem.imem_ack = 1'b0;
        if (np[1:0] == 2'b00) begin
            m_pc = np;
            m_ret++;
            chk("a_req", 64'(imem.imem_req), 64'd1);
            chk("a_addr", imem.imem_addr, m_pc);
        end else begin
            m_fault = 2'b01;
            chk("mis_fault", 64'(fault), 64'(m_fault));
            chk("mis_req", 64'(imem.imem_req), 64'd0);
        end
        chk("a_valid", 64'(inst_valid), 64'd0);
        chk("a_pc", CurrentPC, m_pc);
        chk("a_retired", 64'(retired), exp_ret());
    endtask

    task automatic check_frozen(input int n);
        for (int i = 0; i < n; i++) begin
            imem.imem_ack = 1'($urandom);
            imem.imem_rdata = $urandom();
            advance = 1'($urandom);
            NextPC = {$urandom(), $urandom()};
            @(posedge CLK);
            #1;
            chk("fz_fault", 64'(fault), 64'(m_fault));
            chk("fz_req", 64'(imem.imem_req), 64'd0);
            chk("fz_valid", 64'(inst_valid), 64'd0);
            chk("fz_pc", CurrentPC, m_pc);
            chk("fz_instr", 64'(Instruction), 64'(m_instr));
            chk("fz_retired", 64'(retired), exp_ret());
        end
        imem.imem_ack = 1'b0;
        advance = 1'b0;
    endtask

    initial begin
        imem.imem_ack = 1'b0;
        imem.imem_rdata = '0;

        // Boot and zero-wait stream at one instruction per two cycles.
        do_reset(64'h400);
        for (int k = 0; k < 3; k++) begin
            fetch(0, $urandom());
            do_advance(m_pc + 64'd4);
        end
        chk("stream_ret3", 64'(retired), 64'd3);

        // Branch with wait states.
        fetch(3, 32'h14000010);
        do_advance(64'h440);
        fetch(0, $urandom());
        chk("branch_pc", CurrentPC, 64'h440);

        // Randomized stream; retired wraps past 2^CW-1.
        for (int k = 0; k < 24; k++) begin
            do_advance(rand_pc());
            fetch(int'($urandom_range(0, AT - 1)), $urandom());
            hold_cycles(int'($urandom_range(0, 2)));
        end

        // Misaligned target.
        do_advance(64'h400);
        fetch(0, $urandom());
        do_advance(64'h402);
        check_frozen(10);

        // Timeout: no ack for AT cycles.
        do_reset(64'h400);
        fetch(AT, 32'h0);
        check_frozen(5);

        // Ack on the last allowed cycle wins.
        do_reset(64'h800);
        fetch(AT - 1, 32'hdeadbeef);
        hold_cycles(2);

        // Async reset while FETCH is requesting.
        do_advance(64'h900);
        #3;
        resetl = 1'b0;
        #1;
        check_reset_vals("async");

        // Explicit counter wrap 15 -> 0.
        do_reset(64'h1000);
        for (int k = 0; k < (1 << CW) + 1; k++) begin
            fetch(0, $urandom());
            do_advance(m_pc + 64'd4);
        end
        chk("wrap_ret", 64'(retired), 64'd1);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
